// File: rtl/dram16_pkg.sv
// Shared definitions for the DRAM16 macro responder: FSM encoding, array
// geometry, access-type codes and a one-hot helper.
package dram16_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_ROWS  = 16;
    localparam int NUM_BANKS = 4;

    // Access-type codes shared with the controller-side model.
    localparam logic [1:0] IO_MODEL_WRITE = 2'b01;
    localparam logic [1:0] IO_MODEL_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SHIFT      = 3'd1,
        ST_ARMED      = 3'd2,
        ST_WRITE      = 3'd3,
        ST_WAIT_SENSE = 3'd4
    } state_t;

    // True when exactly one bit of the wordline vector is set.
    function automatic logic is_onehot16(input logic [DATA_W-1:0] v);
        return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/dram16_onehot_dec.sv
// Decodes the one-hot read wordline R_AD[16:1] into a row index (bit k
// selects row k-1) and flags whether the vector is a legal one-hot code.
module dram16_onehot_dec
    import dram16_pkg::*;
(
    input  logic [16:1] i_r_ad,
    output logic [3:0]  o_row,
    output logic        o_onehot
);

    // Priority scan gives a stable index even for illegal vectors; callers
    // must qualify it with o_onehot.
    always_comb begin
        o_row    = '0;
        for (int k = 1; k <= 16; k++) begin
            if (i_r_ad[k]) o_row = 4'(k - 1);
        end
        o_onehot = is_onehot16(i_r_ad);
    end

endmodule

// File: rtl/dram16_macro_responder.sv
// Behavioural stand-in for the DRAM16 analog macro: serial write address,
// delayed array write, one-hot sensed read, sticky protocol-error flag.
// Handshake: a write is accepted in the ARMED cycle where WRI_EN and
// DATA_VALID_IN are both high; a read is accepted in the IDLE cycle where
// RD_EN is high with a one-hot R_AD. Completion is signalled by a
// one-cycle WR_ACK or DATA_RDY pulse; no back-pressure exists.
module dram16_macro_responder
    import dram16_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int WRITE_LAT = 3,
    parameter int SENSE_LAT = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ADD_IN,
    input  logic        ADD_VALID_IN,
    input  logic [1:0]  PC_D_IN,
    input  logic [16:1] D_IN,
    input  logic        DATA_VALID_IN,
    input  logic        WRI_EN,
    input  logic [16:1] R_AD,
    input  logic [1:0]  PC_R_AD,
    input  logic        RD_EN,
    input  logic        VSAEN,
    input  logic        REF_WWL,
    output logic [16:1] DRAM16_data,
    output logic        DATA_RDY,
    output logic        WR_ACK,
    output logic        PROT_ERR,
    output state_t      o_dbg_state
);

    localparam int BCW = $clog2(ADDR_W + 2);
    localparam int WCW = $clog2(WRITE_LAT + 1);
    localparam int SCW = $clog2(SENSE_LAT + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [BCW-1:0] BIT_FULL = BCW'(ADDR_W);
    localparam logic [BCW-1:0] BIT_SAT  = BCW'(ADDR_W + 1);
    localparam logic [WCW-1:0] W_LAST   = WCW'(WRITE_LAT - 1);
    localparam logic [SCW-1:0] S_FULL   = SCW'(SENSE_LAT);
    localparam logic [TCW-1:0] T_LAST   = TCW'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_shift;
    logic [ADDR_W-1:0]   r_row;
    logic [BCW-1:0]      r_bit_cnt;
    logic [WCW-1:0]      r_wcnt;
    logic [SCW-1:0]      r_scnt;
    logic [TCW-1:0]      r_tcnt;
    logic [1:0]          r_wr_bank;
    logic [1:0]          r_rd_bank;
    logic [3:0]          r_rd_row;
    logic [DATA_W-1:0]   r_wr_data;
    logic [16:1]         r_rd_data;
    logic                r_data_rdy;
    logic                r_prot_err;
    logic [DATA_W-1:0]   r_mem [NUM_BANKS][NUM_ROWS];

    logic [3:0]          w_dec_row;
    logic                w_dec_onehot;
    logic                w_shift_start;
    logic                w_shift_bit;
    logic                w_latch_row;
    logic                w_wr_accept;
    logic                w_rd_accept;
    logic                w_err_set;
    logic                w_mem_we;
    logic                w_capture;

    dram16_onehot_dec u_dec (
        .i_r_ad   (R_AD),
        .o_row    (w_dec_row),
        .o_onehot (w_dec_onehot)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_next_state  = r_state;
        w_shift_start = 1'b0;
        w_shift_bit   = 1'b0;
        w_latch_row   = 1'b0;
        w_wr_accept   = 1'b0;
        w_rd_accept   = 1'b0;
        w_err_set     = 1'b0;
        w_mem_we      = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Address path takes priority over a concurrent read request.
                if (ADD_VALID_IN) begin
                    w_shift_start = 1'b1;
                    w_next_state  = ST_SHIFT;
                end else if (RD_EN) begin
                    if (REF_WWL || !w_dec_onehot) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_rd_accept  = 1'b1;
                        w_next_state = ST_WAIT_SENSE;
                    end
                end
            end
            ST_SHIFT: begin
                if (ADD_VALID_IN) begin
                    w_shift_bit = 1'b1;
                end else if (r_bit_cnt == BIT_FULL) begin
                    w_latch_row  = 1'b1;
                    w_next_state = ST_ARMED;
                end else begin
                    w_err_set    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // A fresh address burst replaces the latched row.
                if (ADD_VALID_IN) begin
                    w_shift_start = 1'b1;
                    w_next_state  = ST_SHIFT;
                end else if (WRI_EN && REF_WWL) begin
                    w_err_set = 1'b1;
                end else if (WRI_EN && DATA_VALID_IN) begin
                    w_wr_accept  = 1'b1;
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_wcnt == W_LAST) begin
                    w_mem_we     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_SENSE: begin
                // Capture once VSAEN has been held long enough; timeout otherwise.
                if (r_scnt == S_FULL) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_tcnt == T_LAST) begin
                    w_err_set    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Address shifter, counters, captured operands, read data and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_row      <= '0;
            r_bit_cnt  <= '0;
            r_wcnt     <= '0;
            r_scnt     <= '0;
            r_tcnt     <= '0;
            r_wr_bank  <= '0;
            r_rd_bank  <= '0;
            r_rd_row   <= '0;
            r_wr_data  <= '0;
            r_rd_data  <= '0;
            r_data_rdy <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            if (w_shift_start) begin
                r_shift   <= ADDR_W'(ADD_IN);
                r_bit_cnt <= BCW'(1);
            end else if (w_shift_bit) begin
                r_shift <= {r_shift[ADDR_W-2:0], ADD_IN};
                if (r_bit_cnt != BIT_SAT) r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            if (w_latch_row) r_row <= r_shift;

            if (w_wr_accept) begin
                r_wr_data <= D_IN;
                r_wr_bank <= PC_D_IN;
                r_wcnt    <= '0;
            end else if (r_state == ST_WRITE) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end

            if (w_rd_accept) begin
                r_rd_row  <= w_dec_row;
                r_rd_bank <= PC_R_AD;
                r_scnt    <= '0;
                r_tcnt    <= '0;
            end else if (r_state == ST_WAIT_SENSE) begin
                r_tcnt <= r_tcnt + TCW'(1);
                r_scnt <= VSAEN ? r_scnt + SCW'(1) : '0;
            end

            if (w_capture) r_rd_data <= r_mem[r_rd_bank][r_rd_row];
            r_data_rdy <= w_capture;

            if (w_err_set)                       r_prot_err <= 1'b1;
            else if (w_wr_accept || w_rd_accept) r_prot_err <= 1'b0;
        end
    end

    // Array update; no reset so a reset during WRITE leaves contents intact.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_bank][r_row] <= r_wr_data;
    end

    assign DRAM16_data = r_rd_data;
    assign DATA_RDY    = r_data_rdy;
    assign WR_ACK      = w_mem_we;
    assign PROT_ERR    = r_prot_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/dram16_macro_responder.md
Name: dram16_macro_responder

Overview:
- Synthesizable responder for the DRAM16 macro pin interface driven by the write/read controller.
- Receives:
  - the serial write address (ADD_IN/ADD_VALID_IN)
  - write data (D_IN/DATA_VALID_IN/WRI_EN)
  - one-hot read wordline (R_AD) with sensing (RD_EN/VSAEN)
- Returns DRAM16_data to the controller.
- Stands in for the analog macro in FPGA prototyping and closed-loop controller benches.
- Storage: 4 banks x 16 rows x 16 bits.

Parameters:
- ADDR_W, 4, serial write-address length in bits (row index); 2^ADDR_W must equal 16.
- WRITE_LAT, 3, cycles from write launch to array update (write-wordline pulse time).
- SENSE_LAT, 2, cycles VSAEN must be held high before data is captured.
- TIMEOUT, 32, max cycles in WAIT_SENSE before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ADD_IN  in  1  serial write address, MSB first
- ADD_VALID_IN  in  1  qualifies ADD_IN each cycle
- PC_D_IN  in  2  write bank select
- D_IN  in  16 [16:1]  write data
- DATA_VALID_IN  in  1  qualifies D_IN
- WRI_EN  in  1  write enable
- R_AD  in  16 [16:1]  one-hot read wordline; R_AD[k] selects row k-1
- PC_R_AD  in  2  read bank select
- RD_EN  in  1  read enable
- VSAEN  in  1  sense-amp enable
- REF_WWL  in  1  refresh wordline; blocks new accesses while high
- DRAM16_data  out  16 [16:1]  read data, held until next read
- DATA_RDY  out  1  one-cycle pulse when DRAM16_data updates
- WR_ACK  out  1  one-cycle pulse when array write completes
- PROT_ERR  out  1  sticky protocol-error flag; cleared by the next accepted access

Behaviour:
- Reset values:
  - DRAM16_data=0, DATA_RDY=0, WR_ACK=0, PROT_ERR=0
  - FSM=IDLE; shift register and bit counter = 0
  - Array contents are not reset; the bench must write before reading.
- FSM states and transitions:
  - IDLE → SHIFT when ADD_VALID_IN=1.
    - The first bit is captured in the same cycle.
  - SHIFT: shift ADD_IN in while ADD_VALID_IN=1 and count bits.
    - On ADD_VALID_IN falling with count==ADD_W: latch the row address and go to ARMED.
    - Any other count: set PROT_ERR and go to IDLE.
  - ARMED → WRITE on the first cycle with WRI_EN=1 and DATA_VALID_IN=1.
    - D_IN and PC_D_IN are captured in that cycle.
  - WRITE: count WRITE_LAT cycles.
    - On the last cycle, update mem[bank][row], pulse WR_ACK and go to IDLE.
    - Inputs are ignored during WRITE.
  - IDLE → WAIT_SENSE when RD_EN=1 and R_AD is exactly one-hot.
    - R_AD and PC_R_AD are captured in that cycle.
    - RD_EN with non-one-hot R_AD (zero or multi-hot): set PROT_ERR and stay IDLE.
  - WAIT_SENSE: count consecutive VSAEN=1 cycles.
    - VSAEN dropping early resets the count.
    - At SENSE_LAT: DRAM16_data <= mem[bank][row], pulse DATA_RDY next cycle, go to IDLE.
    - At TIMEOUT cycles: set PROT_ERR, leave DRAM16_data unchanged, go to IDLE.
- Latencies:
  - Write: WR_ACK asserts WRITE_LAT cycles after the data-accept cycle.
  - Read: DATA_RDY asserts SENSE_LAT+1 cycles after the first VSAEN=1 cycle.
- Simultaneous events and boundary conditions:
  - RD_EN and ADD_VALID_IN both high in IDLE: the write address path wins and RD_EN is ignored.
  - WRI_EN or RD_EN while REF_WWL=1: access not accepted, PROT_ERR set.
  - ADD_VALID_IN while in ARMED: restarts SHIFT and discards the previously latched address.
  - Read-after-write to the same location returns the new data once WR_ACK has pulsed.
  - Address bits beyond ADDR_W are an error, not wrap-around.
- Reset mid-operation (async assert):
  - Any pending write is aborted with the array unmodified.
  - All outputs return to reset values immediately.
- DATA_RDY and WR_ACK are never high in the same cycle.

Decomposition:
- Shared package/header dram16_pkg:
  - FSM state encodings (IDLE, SHIFT, ARMED, WRITE, WAIT_SENSE)
  - DATA_W=16, NUM_ROWS=16, NUM_BANKS=4
  - IO_MODEL codes: 01=write, 10=read
- One natural sub-module: dram16_onehot_dec.
  - R_AD → row index, plus a one-hot-valid flag.
  - Reusable by the controller-side checker.

Test Plan:
- Write path: shift address 4'b0101 MSB first, PC_D_IN=2, D_IN=16'hA5A5 → WR_ACK exactly 3 cycles after data accept; PROT_ERR=0.
- Read back: RD_EN with R_AD=16'h0020, PC_R_AD=2, VSAEN held 2 cycles → DRAM16_data=16'hA5A5 with one DATA_RDY pulse.
- Bad address length: 3-bit serial burst → PROT_ERR=1, FSM IDLE, no WR_ACK. Next valid write clears PROT_ERR.
- Non-one-hot read: R_AD=16'h0011 with RD_EN → PROT_ERR=1, DRAM16_data unchanged, no DATA_RDY.
- Sense timeout: RD_EN valid, VSAEN never asserted → PROT_ERR at cycle 32, return to IDLE. A VSAEN 1-cycle glitch does not capture data.
- Reset mid-write: rst_n low during WRITE cycle 2 → outputs 0 at once. A subsequent read of that location returns prior contents (pre-write 16'h1234).
